// File: rtl/fir_stream_pkg.sv
// Shared definitions for the FIR streaming blocks (source, filter, sink).
package fir_stream_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Requested pass length saturates at the table depth.
  function automatic int clamp_len(input int req_len, input int depth);
    return (req_len > depth) ? depth : req_len;
  endfunction

endpackage

// File: rtl/fir_axis_sample_source_if.sv
// AXI-Stream sample channel between the sample source and the FIR filter input.
interface fir_axis_sample_source_if #(
  parameter int DATA_W = 16
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/fir_sample_ram.sv
// Sample table: synchronous write, asynchronous read (read returns pre-write contents on a colliding edge).
module fir_sample_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_axis_sample_source.sv
// AXI-Stream master that replays a loaded sample table once or continuously, with optional
// idle-cycle pacing between transfers and full tready backpressure.
module fir_axis_sample_source
  import fir_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 5,
  parameter int RATE_W = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [ADDR_W:0]          length,
  input  logic [RATE_W-1:0]        rate_div,
  fir_axis_sample_source_if.master m_axis_data,
  output logic                     busy,
  output logic                     done
);

  localparam int LEN_W = ADDR_W + 1;

  logic [1:0]        state_reg,    state_next;
  logic [ADDR_W-1:0] rd_ptr_reg,   rd_ptr_next;
  logic [RATE_W-1:0] gap_cnt_reg,  gap_cnt_next;
  logic [LEN_W-1:0]  len_reg,      len_next;
  logic [RATE_W-1:0] rate_reg,     rate_next;
  logic              loop_reg,     loop_next;
  logic              stop_req_reg, stop_req_next;
  logic              tvalid_reg,   tvalid_next;
  logic [DATA_W-1:0] tdata_reg,    tdata_next;
  logic              tlast_reg,    tlast_next;
  logic              busy_reg,     busy_next;
  logic              done_reg,     done_next;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  len_m1;
  logic [ADDR_W-1:0] wrap_ptr;
  logic              at_last;
  logic              next_is_last;
  logic              xfer;
  logic              stopping;

  fir_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign len_clamped  = LEN_W'(clamp_len(int'(length), DEPTH));
  assign len_m1       = len_reg - LEN_W'(1);
  assign at_last      = ({1'b0, rd_ptr_reg} == len_m1);
  assign wrap_ptr     = at_last ? '0 : rd_ptr_reg + ADDR_W'(1);
  assign next_is_last = ({1'b0, wrap_ptr} == len_m1);
  assign xfer         = tvalid_reg & m_axis_data.tready;
  // A stop arriving on the same edge as a transfer ends the pass there too.
  assign stopping     = stop_req_reg | stop;

  always_comb begin
    state_next    = state_reg;
    rd_ptr_next   = rd_ptr_reg;
    gap_cnt_next  = gap_cnt_reg;
    len_next      = len_reg;
    rate_next     = rate_reg;
    loop_next     = loop_reg;
    stop_req_next = stop_req_reg;
    tvalid_next   = tvalid_reg;
    tdata_next    = tdata_reg;
    tlast_next    = tlast_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    rd_addr       = '0;

    case (state_reg)
      ST_IDLE: begin
        if (start && !stop && (length != '0)) begin
          len_next      = len_clamped;
          rate_next     = rate_div;
          loop_next     = loop_en;
          rd_ptr_next   = '0;
          stop_req_next = 1'b0;
          tdata_next    = rd_data;
          tlast_next    = (len_clamped == LEN_W'(1));
          tvalid_next   = 1'b1;
          busy_next     = 1'b1;
          state_next    = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (xfer) begin
          if (stopping || (at_last && !loop_reg)) begin
            tvalid_next   = 1'b0;
            tlast_next    = 1'b0;
            busy_next     = 1'b0;
            done_next     = 1'b1;
            stop_req_next = 1'b0;
            rd_ptr_next   = '0;
            state_next    = ST_IDLE;
          end else begin
            rd_ptr_next = wrap_ptr;
            if (rate_reg == '0) begin
              rd_addr    = wrap_ptr;
              tdata_next = rd_data;
              tlast_next = next_is_last;
            end else begin
              tvalid_next  = 1'b0;
              tlast_next   = 1'b0;
              gap_cnt_next = rate_reg;
              state_next   = ST_GAP;
            end
          end
        end else if (stop) begin
          stop_req_next = 1'b1;
        end
      end

      ST_GAP: begin
        if (stopping) begin
          busy_next     = 1'b0;
          done_next     = 1'b1;
          stop_req_next = 1'b0;
          rd_ptr_next   = '0;
          gap_cnt_next  = '0;
          state_next    = ST_IDLE;
        end else if (gap_cnt_reg == RATE_W'(1)) begin
          // rd_ptr already advanced when the gap began.
          rd_addr      = rd_ptr_reg;
          tdata_next   = rd_data;
          tlast_next   = at_last;
          tvalid_next  = 1'b1;
          gap_cnt_next = '0;
          state_next   = ST_PLAY;
        end else begin
          gap_cnt_next = gap_cnt_reg - RATE_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg    <= ST_IDLE;
      rd_ptr_reg   <= '0;
      gap_cnt_reg  <= '0;
      len_reg      <= '0;
      rate_reg     <= '0;
      loop_reg     <= 1'b0;
      stop_req_reg <= 1'b0;
      tvalid_reg   <= 1'b0;
      tdata_reg    <= '0;
      tlast_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_ptr_reg   <= rd_ptr_next;
      gap_cnt_reg  <= gap_cnt_next;
      len_reg      <= len_next;
      rate_reg     <= rate_next;
      loop_reg     <= loop_next;
      stop_req_reg <= stop_req_next;
      tvalid_reg   <= tvalid_next;
      tdata_reg    <= tdata_next;
      tlast_reg    <= tlast_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign m_axis_data.tvalid = tvalid_reg;
  assign m_axis_data.tdata  = tdata_reg;
  assign m_axis_data.tlast  = tlast_reg;
  assign busy               = busy_reg;
  assign done               = done_reg;

endmodule

// File: tb/tb_fir_axis_sample_source.sv
// Self-checking bench: scoreboard of expected samples checked on each handshake, plus
// a table of playback vectors and hand-written backpressure/stop/reset sequences.
module tb_fir_axis_sample_source;

  logic        aclk;
  logic        aresetn;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [5:0]  length;
  logic [7:0]  rate_div;
  logic        tready;
  logic        busy;
  logic        done;

  fir_axis_sample_source_if #(.DATA_W(16)) axis ();
  assign axis.tready = tready;

  fir_axis_sample_source #(
    .DATA_W (16),
    .DEPTH  (32),
    .ADDR_W (5),
    .RATE_W (8)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .length      (length),
    .rate_div    (rate_div),
    .m_axis_data (axis),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int len;
    int rate;
    int exp_n;
    int exp_span;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] tbl_model [32];
  vec_t        vecs [7];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int last_xfer_cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] data_prev = '0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: a handshake seen here completes on the next rising edge.
  always @(negedge aclk) begin
    exp_t e;
    if (stall_prev) begin
      chk("hold_tvalid", {31'd0, axis.tvalid}, 32'd1);
      chk("hold_tdata", {16'd0, axis.tdata}, {16'd0, data_prev});
    end
    stall_prev = aresetn && axis.tvalid && !tready;
    data_prev  = axis.tdata;
    if (aresetn && axis.tvalid && tready) begin
      xfer_cnt++;
      last_xfer_cyc = cyc + 1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("xfer %0d: tdata=%0h tlast=%0b (exp %0h/%0b)", xfer_cnt, axis.tdata, axis.tlast, e.data, e.last);
        chk("xfer_tdata", {16'd0, axis.tdata}, {16'd0, e.data});
        chk("xfer_tlast", {31'd0, axis.tlast}, {31'd0, e.last});
      end
    end
    if (aresetn && done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr_tbl(input int a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    tbl_model[a] = d;
  endtask

  task automatic push_pass(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{tbl_model[i], (i == n - 1)});
  endtask

  task automatic start_play(input int len, input int rate, input logic lp);
    length   = 6'(len);
    rate_div = 8'(rate);
    loop_en  = lp;
    start    = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int d0, input int bound);
    for (int k = 0; k < bound && done_cnt == d0; k++) tick();
  endtask

  task automatic post_idle(input string nm, input int d0);
    chk({nm, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_busy0"}, {31'd0, busy}, 32'd0);
    chk({nm, "_tvalid0"}, {31'd0, axis.tvalid}, 32'd0);
    chk({nm, "_done0"}, {31'd0, done}, 32'd0);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d0;
    int x0;
    aresetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; length = '0; rate_div = '0;
    tready = 1'b1;

    vecs[0] = '{4, 0, 4, 4};
    vecs[1] = '{4, 2, 4, 10};
    vecs[2] = '{1, 0, 1, 1};
    vecs[3] = '{40, 0, 32, 32};
    vecs[4] = '{32, 3, 32, 125};
    vecs[5] = '{7, 1, 7, 13};
    vecs[6] = '{3, 255, 3, 513};

    repeat (3) tick();
    chk("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    chk("rst_tdata", {16'd0, axis.tdata}, 32'd0);
    chk("rst_tlast", {31'd0, axis.tlast}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    aresetn = 1'b1;

    // Table write while idle; entries 0..3 hold 1..4.
    for (int i = 0; i < 32; i++) wr_tbl(i, (i < 4) ? 16'(i + 1) : (16'hC000 ^ 16'(i * 291)));

    // Table-driven playback passes.
    for (int v = 0; v < 7; v++) begin
      d0 = done_cnt;
      x0 = xfer_cnt;
      push_pass(vecs[v].exp_n);
      start_play(vecs[v].len, vecs[v].rate, 1'b0);
      chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd1);
      wait_done(d0, 2000);
      chk($sformatf("vec%0d_count", v), 32'(xfer_cnt - x0), 32'(vecs[v].exp_n));
      chk($sformatf("vec%0d_span", v), 32'(last_xfer_cyc - start_cyc), 32'(vecs[v].exp_span));
      chk($sformatf("vec%0d_done_lat", v), 32'(done_cyc), 32'(last_xfer_cyc));
      post_idle($sformatf("vec%0d", v), d0);
    end

    // Backpressure: tready low for 3 cycles while sample 2 is presented.
    d0 = done_cnt; x0 = xfer_cnt;
    push_pass(4);
    start_play(4, 0, 1'b0);
    tick();
    tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_tvalid", {31'd0, axis.tvalid}, 32'd1);
      chk("stall_tdata", {16'd0, axis.tdata}, 32'd2);
    end
    tready = 1'b1;
    wait_done(d0, 50);
    chk("stall_count", 32'(xfer_cnt - x0), 32'd4);
    chk("stall_span", 32'(last_xfer_cyc - start_cyc), 32'd7);
    post_idle("stall", d0);

    // Loop of 3, stop requested while stalled on the second pass's sample 2.
    d0 = done_cnt; x0 = xfer_cnt;
    sb.push_back('{16'd1, 1'b0}); sb.push_back('{16'd2, 1'b0}); sb.push_back('{16'd3, 1'b1});
    sb.push_back('{16'd1, 1'b0}); sb.push_back('{16'd2, 1'b0});
    start_play(3, 0, 1'b1);
    repeat (4) tick();
    tready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("stop_hold_tvalid", {31'd0, axis.tvalid}, 32'd1);
    chk("stop_hold_tdata", {16'd0, axis.tdata}, 32'd2);
    chk("stop_no_done_yet", 32'(done_cnt - d0), 32'd0);
    tready = 1'b1;
    wait_done(d0, 50);
    chk("stop_count", 32'(xfer_cnt - x0), 32'd5);
    post_idle("stop", d0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stop_quiet", {31'd0, axis.tvalid}, 32'd0);
    end
    loop_en = 1'b0;

    // Stop while in the pacing gap ends playback on the next edge.
    d0 = done_cnt;
    sb.push_back('{16'd1, 1'b0});
    start_play(4, 5, 1'b0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("gapstop_done", {31'd0, done}, 32'd1);
    chk("gapstop_busy", {31'd0, busy}, 32'd0);
    tick();
    post_idle("gapstop", d0);

    // Reset mid-playback drops tvalid; table survives.
    d0 = done_cnt;
    sb.push_back('{16'd1, 1'b0});
    start_play(4, 0, 1'b0);
    tick();
    tready = 1'b0;
    tick();
    aresetn = 1'b0;
    tick();
    chk("midrst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    chk("midrst_tdata", {16'd0, axis.tdata}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    aresetn = 1'b1;
    tready = 1'b1;
    tick();
    chk("midrst_idle", {31'd0, axis.tvalid}, 32'd0);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_sb", 32'(sb.size()), 32'd0);
    d0 = done_cnt; x0 = xfer_cnt;
    push_pass(4);
    start_play(4, 0, 1'b0);
    chk("restart_first", {16'd0, axis.tdata}, 32'd1);
    wait_done(d0, 50);
    chk("restart_count", 32'(xfer_cnt - x0), 32'd4);
    post_idle("restart", d0);

    // length=0 start is ignored.
    d0 = done_cnt;
    length = '0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("len0_busy", {31'd0, busy}, 32'd0);
      chk("len0_tvalid", {31'd0, axis.tvalid}, 32'd0);
    end
    start = 1'b0;

    // start together with stop in idle is ignored.
    length = 6'd4;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("startstop_tvalid", {31'd0, axis.tvalid}, 32'd0);
    chk("len0_startstop_no_done", 32'(done_cnt - d0), 32'd0);

    // Start and config changes while busy are ignored.
    d0 = done_cnt; x0 = xfer_cnt;
    push_pass(4);
    start_play(4, 2, 1'b0);
    start = 1'b1; length = 6'd8; rate_div = 8'd0; loop_en = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    wait_done(d0, 50);
    chk("busystart_count", 32'(xfer_cnt - x0), 32'd4);
    chk("busystart_span", 32'(last_xfer_cyc - start_cyc), 32'd10);
    post_idle("busystart", d0);
    loop_en = 1'b0;

    // Write to index 0 on the start edge: old value is presented, new value next pass.
    d0 = done_cnt;
    push_pass(4);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'hBEEF;
    start_play(4, 0, 1'b0);
    wr_en = 1'b0;
    tbl_model[0] = 16'hBEEF;
    wait_done(d0, 50);
    post_idle("rbw", d0);
    d0 = done_cnt;
    push_pass(2);
    start_play(2, 0, 1'b0);
    wait_done(d0, 50);
    post_idle("rbw_new", d0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
